// File: rtl/vector_reverse_ctrl.sv
// vector_reverse_ctrl: buffers one frame of up to DEPTH words and replays it
// in reverse arrival order over a valid/ready stream.
// Optional feature macro: VECTOR_BIT_REVERSE_EN -- when defined, each output
// word is also bit-reversed; otherwise words pass through unchanged.
module vector_reverse_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [7:0]       r_frame_cnt;
  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_frame_in_done;
  logic             w_frame_out_done;

  // Output word mapping: bit reversal when the feature is built in.
  function automatic logic [WIDTH-1:0] f_map(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
`ifdef VECTOR_BIT_REVERSE_EN
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = w[WIDTH-1-i];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  // State register; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; outputs are purely a function of state.
  always_comb begin
    w_state_nxt      = r_state;
    in_ready         = 1'b0;
    out_valid        = 1'b0;
    busy             = 1'b0;
    out_last         = 1'b0;
    w_in_hs          = 1'b0;
    w_out_hs         = 1'b0;
    w_frame_in_done  = 1'b0;
    w_frame_out_done = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        w_in_hs  = in_valid;
        // A full buffer closes the frame whether or not in_last is set.
        if (w_in_hs && (in_last || (r_wr_ptr == LAST_IDX))) begin
          w_frame_in_done = 1'b1;
          w_state_nxt     = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (r_rd_ptr == '0);
        w_out_hs  = out_ready;
        if (w_out_hs && (r_rd_ptr == '0)) begin
          w_frame_out_done = 1'b1;
          w_state_nxt      = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // Read port: the word under rd_ptr is held until the downstream takes it.
  always_comb begin
    out_data = f_map(r_mem[r_rd_ptr]);
  end

  // Pointers and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_in_hs) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        // Drain starts at the word just written.
        if (w_frame_in_done) begin
          r_rd_ptr <= r_wr_ptr;
        end
      end
      if (w_out_hs) begin
        if (w_frame_out_done) begin
          r_wr_ptr    <= '0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_rd_ptr <= r_rd_ptr - AW'(1);
        end
      end
    end
  end

  // Frame buffer; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vector_reverse_ctrl.sv
// Self-checking bench for vector_reverse_ctrl: a queue-based frame model is
// compared against the DUT every cycle, plus directed literal scenarios.
module tb_vector_reverse_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last, busy;
  logic [7:0] out_data, frame_cnt;

  vector_reverse_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: words collected for the current frame, words still to be emitted
  // (front = next out), and completed frame count.
  bit         m_draining = 1'b0;
  logic [7:0] m_buf[$];
  logic [7:0] m_exp[$];
  int         m_frames = 0;
  logic [8:0] got_q[$];
  int         ready_mode = 0;
  bit         rdy_tog = 1'b1;

  function automatic logic [7:0] f_ref(input logic [7:0] w);
    logic [7:0] r;
`ifdef VECTOR_BIT_REVERSE_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by the
  // handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      m_draining = 1'b0;
      m_buf.delete();
      m_exp.delete();
      m_frames = 0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_draining});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_draining});
      chk("busy", {31'd0, busy}, {31'd0, m_draining});
      chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, m_frames[7:0]});
      if (m_draining) begin
        chk("out_data", {24'd0, out_data}, {24'd0, f_ref(m_exp[0])});
        chk("out_last", {31'd0, out_last}, {31'd0, m_exp.size() == 1});
        if (out_ready) begin
          if (out_valid) got_q.push_back({out_last, out_data});
          void'(m_exp.pop_front());
          if (m_exp.size() == 0) begin
            m_draining = 1'b0;
            m_frames++;
          end
        end
      end else if (in_valid) begin
        m_buf.push_back(in_data);
        if (in_last || m_buf.size() == DEPTH) begin
          m_exp.delete();
          foreach (m_buf[i]) m_exp.push_front(m_buf[i]);
          m_buf.delete();
          m_draining = 1'b1;
        end
      end
    end
  end

  // Downstream ready generator: 0 always ready, 1 alternating, 2 random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = rdy_tog;
        rdy_tog = !rdy_tog;
      end
      2: out_ready = ($urandom % 3) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    bit hs;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      if (hs) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no handshake expected handshake for %0h", d);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (!m_draining) done = 1'b1;
      else tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got draining expected idle");
    end
  endtask

  task automatic expect_frame(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      chk({name, "_data"}, {24'd0, got_q[i][7:0]}, {24'd0, exp[i]});
      chk({name, "_last"}, {31'd0, got_q[i][8]}, {31'd0, i == exp.size() - 1});
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    bit done;
    ready_mode = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("init_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("init_in_ready", {31'd0, in_ready}, 32'd1);
    chk("init_out_valid", {31'd0, out_valid}, 32'd0);

    // Full frame 0x01..0x08 back to back.
    got_q.delete();
    for (int i = 1; i <= 8; i++) send_word(8'(i), 1'b0);
    in_valid = 1'b0;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_first", {24'd0, out_data}, {24'd0, f_ref(8'h08)});
    wait_idle();
    q.delete();
    for (int i = 8; i >= 1; i--) q.push_back(f_ref(8'(i)));
    expect_frame("full", q);
    chk("full_frame_cnt", {24'd0, frame_cnt}, 32'd1);

    // Short frame closed by in_last.
    got_q.delete();
    send_word(8'hA1, 1'b0);
    send_word(8'hB2, 1'b0);
    send_word(8'hC3, 1'b1);
    in_valid = 1'b0;
    chk("short_in_ready", {31'd0, in_ready}, 32'd0);
    wait_idle();
    q = '{f_ref(8'hC3), f_ref(8'hB2), f_ref(8'hA1)};
    expect_frame("short", q);

    // Full frame with alternating downstream stalls.
    got_q.delete();
    ready_mode = 1;
    rdy_tog = 1'b1;
    for (int i = 1; i <= 8; i++) send_word(8'(i), 1'b0);
    in_valid = 1'b0;
    wait_idle();
    q.delete();
    for (int i = 8; i >= 1; i--) q.push_back(f_ref(8'(i)));
    expect_frame("stall", q);
    ready_mode = 0;

    // Reset in the middle of a drain, then a fresh two-word frame.
    got_q.delete();
    for (int i = 1; i <= 8; i++) send_word(8'(i), 1'b0);
    in_valid = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      if (got_q.size() >= 4) done = 1'b1;
      else tick();
    end
    chk("mid_hs_count", got_q.size(), 32'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    got_q.delete();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    q = '{f_ref(8'h22), f_ref(8'h11)};
    expect_frame("post_rst", q);

    // Single-word frame: hand-computed mapped value.
    got_q.delete();
    send_word(8'h12, 1'b1);
    in_valid = 1'b0;
    wait_idle();
`ifdef VECTOR_BIT_REVERSE_EN
    q = '{8'h48};
`else
    q = '{8'h12};
`endif
    expect_frame("single", q);

    // 256 two-word frames: counter wraps back to zero.
    pulse_reset();
    for (int f = 0; f < 256; f++) begin
      got_q.delete();
      send_word(8'h01, 1'b0);
      send_word(8'h02, 1'b1);
      in_valid = 1'b0;
      wait_idle();
      if (f == 254) chk("cnt_255", {24'd0, frame_cnt}, 32'd255);
    end
`ifdef VECTOR_BIT_REVERSE_EN
    q = '{8'h40, 8'h80};
`else
    q = '{8'h02, 8'h01};
`endif
    expect_frame("wrap_frame", q);
    chk("cnt_wrap", {24'd0, frame_cnt}, 32'd0);

    // Randomized traffic with occasional resets; the compare process checks.
    ready_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      in_valid = ($urandom % 4) != 0;
      in_data = 8'($urandom);
      in_last = ($urandom % 4) == 0;
      rst = ($urandom % 700) == 0;
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    ready_mode = 0;
    tick();
    wait_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
